// File: rtl/audio_pkg.sv
// Shared types and constants for the voice allocator.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DECIDE,
    GAP
  } state_t;

  localparam int NOTEBITS_DEF = 7;
  localparam int AGEBITS_DEF  = 8;

  // Width needed to index n items (at least one bit).
  function automatic int idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/voice_age.sv
// Per-voice saturating age counter: counts while the gate is high, clear wins.
module voice_age #(
  parameter int AGEBITS = 8
) (
  input  logic               sample_clock,
  input  logic               resetn,
  input  logic               clr,
  input  logic               inc,
  output logic [AGEBITS-1:0] age
);

  // Clear on (re)allocation, otherwise count up and stick at full scale.
  always_ff @(posedge sample_clock or negedge resetn) begin
    if (!resetn) begin
      age <= '0;
    end else if (clr) begin
      age <= '0;
    end else if (inc && (age != '1)) begin
      age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: serial scan of the voices, then reuse, retrigger
// or steal the oldest sounding voice with a gate-low gap before retrigger.
//
// state  | meaning
// IDLE   | ready for an event; latches it on acceptance
// SCAN   | one voice examined per cycle: match / first free / oldest
// DECIDE | applies the outcome of the scan to a single target voice
// GAP    | target gate held low for GAPCYCLES before it rises again
module voice_alloc
  import audio_pkg::*;
#(
  parameter int NVOICES   = 4,
  parameter int NOTEBITS  = NOTEBITS_DEF,
  parameter int AGEBITS   = AGEBITS_DEF,
  parameter int GAPCYCLES = 2
) (
  input  logic                        sample_clock,
  input  logic                        resetn,
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic                        ev_on,
  input  logic [NOTEBITS-1:0]         ev_note,
  output logic [NVOICES-1:0]          gate,
  output logic [NVOICES*NOTEBITS-1:0] voice_note,
  output logic                        steal
);

  localparam int IW = idx_bits(NVOICES);
  localparam int GW = idx_bits(GAPCYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NVOICES - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAPCYCLES - 1);

  state_t state, state_nxt;

  logic                                on_q;
  logic [NOTEBITS-1:0]                 note_q;
  logic [IW-1:0]                       scan_idx;
  logic                                match_found, free_found, old_found;
  logic [IW-1:0]                       match_idx, free_idx, old_idx, target_idx;
  logic [GW-1:0]                       gap_cnt;
  logic [NVOICES-1:0][NOTEBITS-1:0]    note_arr;
  logic [NVOICES-1:0][AGEBITS-1:0]     age;
  logic [NVOICES-1:0]                  age_clr;
  logic decide_off, decide_retrig, decide_free, decide_steal, gap_done;

  assign voice_note = note_arr;

  // State register.
  always_ff @(posedge sample_clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and the single-cycle decision strobes.
  always_comb begin
    state_nxt     = state;
    ev_ready      = 1'b0;
    steal         = 1'b0;
    decide_off    = 1'b0;
    decide_retrig = 1'b0;
    decide_free   = 1'b0;
    decide_steal  = 1'b0;
    gap_done      = 1'b0;
    case (state)
      IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) state_nxt = SCAN;
      end
      SCAN: begin
        if (scan_idx == LAST_IDX) state_nxt = DECIDE;
      end
      DECIDE: begin
        state_nxt = IDLE;
        if (!on_q) begin
          decide_off = match_found;
        end else if (match_found) begin
          decide_retrig = 1'b1;
          state_nxt     = GAP;
        end else if (free_found) begin
          decide_free = 1'b1;
        end else begin
          decide_steal = 1'b1;
          steal        = 1'b1;
          state_nxt    = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          gap_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Event latch, scan bookkeeping and the per-voice gate/note arrays.
  // Oldest compares live ages of the candidate and the scanned voice, so the
  // result is not skewed by ages advancing during the scan.
  always_ff @(posedge sample_clock or negedge resetn) begin
    if (!resetn) begin
      on_q        <= 1'b0;
      note_q      <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      target_idx  <= '0;
      gap_cnt     <= '0;
      gate        <= '0;
      note_arr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_valid) begin
            on_q        <= ev_on;
            note_q      <= ev_note;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
          end
        end
        SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          if (gate[scan_idx]) begin
            if (!match_found && (note_arr[scan_idx] == note_q)) begin
              match_found <= 1'b1;
              match_idx   <= scan_idx;
            end
            if (!old_found || (age[scan_idx] > age[old_idx])) begin
              old_found <= 1'b1;
              old_idx   <= scan_idx;
            end
          end else if (!free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
        end
        DECIDE: begin
          gap_cnt <= GAP_INIT;
          if (decide_off) gate[match_idx] <= 1'b0;
          if (decide_retrig) begin
            gate[match_idx] <= 1'b0;
            target_idx      <= match_idx;
          end
          if (decide_free) begin
            note_arr[free_idx] <= note_q;
            gate[free_idx]     <= 1'b1;
          end
          if (decide_steal) begin
            target_idx        <= old_idx;
            note_arr[old_idx] <= note_q;
            gate[old_idx]     <= 1'b0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_done) gate[target_idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NVOICES; i++) begin : g_age
    assign age_clr[i] = (decide_free && (free_idx == IW'(i))) ||
                        (gap_done && (target_idx == IW'(i)));
    voice_age #(.AGEBITS(AGEBITS)) u_age (
      .sample_clock (sample_clock),
      .resetn       (resetn),
      .clr          (age_clr[i]),
      .inc          (gate[i]),
      .age          (age[i])
    );
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench: event-level reference model compared every cycle.
module tb_voice_alloc;

  localparam int N    = 4;
  localparam int NB   = 7;
  localparam int AB   = 8;
  localparam int G    = 2;
  localparam int AMAX = (1 << AB) - 1;

  logic              sample_clock = 1'b0;
  logic              resetn       = 1'b0;
  logic              ev_valid     = 1'b0;
  logic              ev_on        = 1'b0;
  logic [NB-1:0]     ev_note      = '0;
  logic              ev_ready;
  logic              steal;
  logic [N-1:0]      gate;
  logic [N*NB-1:0]   voice_note;

  int checks = 0;
  int errors = 0;

  // Reference model: voice table plus the pending event outcome.
  bit m_gate [N];
  int m_note [N];
  int m_age  [N];
  bit m_busy;
  int m_cnt;
  int m_kind;   // 0 off-unmatched, 1 off, 2 retrigger, 3 free, 4 steal
  int m_idx;
  int m_tnote;
  int steal_seen;
  int accepts;

  voice_alloc #(.NVOICES(N), .NOTEBITS(NB), .AGEBITS(AB), .GAPCYCLES(G)) dut (
    .sample_clock (sample_clock),
    .resetn       (resetn),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_note      (ev_note),
    .gate         (gate),
    .voice_note   (voice_note),
    .steal        (steal)
  );

  always #5 sample_clock = ~sample_clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_gate[i] = 1'b0; m_note[i] = 0; m_age[i] = 0;
    end
    m_busy = 1'b0; m_cnt = 0; m_kind = 0; m_idx = 0; m_tnote = 0;
  endtask

  // Outcome of an event from the voice table as it stands at acceptance.
  task automatic model_decide(input bit on, input int note);
    int match, free, oldest;
    match = -1; free = -1; oldest = -1;
    for (int i = 0; i < N; i++) begin
      if (m_gate[i] && m_note[i] == note && match < 0) match = i;
      if (!m_gate[i] && free < 0) free = i;
      if (m_gate[i] && (oldest < 0 || m_age[i] > m_age[oldest])) oldest = i;
    end
    m_tnote = note;
    if (!on)           begin m_kind = (match >= 0) ? 1 : 0; m_idx = match; end
    else if (match >= 0) begin m_kind = 2; m_idx = match; end
    else if (free >= 0)  begin m_kind = 3; m_idx = free; end
    else                 begin m_kind = 4; m_idx = oldest; end
  endtask

  // Advance the model across one rising edge.
  task automatic model_edge();
    bit clr [N];
    bit g_old [N];
    for (int i = 0; i < N; i++) begin clr[i] = 1'b0; g_old[i] = m_gate[i]; end
    if (!m_busy) begin
      if (ev_valid) begin
        model_decide(ev_on, int'(ev_note));
        m_busy = 1'b1; m_cnt = 0; accepts++;
      end
    end else begin
      m_cnt++;
      if (m_cnt == N + 1) begin
        case (m_kind)
          0: m_busy = 1'b0;
          1: begin m_gate[m_idx] = 1'b0; m_busy = 1'b0; end
          2: m_gate[m_idx] = 1'b0;
          3: begin
            m_note[m_idx] = m_tnote; m_gate[m_idx] = 1'b1;
            clr[m_idx] = 1'b1; m_busy = 1'b0;
          end
          default: begin m_note[m_idx] = m_tnote; m_gate[m_idx] = 1'b0; end
        endcase
      end else if (m_cnt == N + 1 + G) begin
        m_gate[m_idx] = 1'b1; clr[m_idx] = 1'b1; m_busy = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (clr[i]) m_age[i] = 0;
      else if (g_old[i] && m_age[i] < AMAX) m_age[i]++;
    end
  endtask

  task automatic check_all();
    logic [N-1:0]         eg;
    logic [N*NB-1:0]      en;
    logic [N-1:0][AB-1:0] ea;
    bit es;
    for (int i = 0; i < N; i++) begin
      eg[i] = m_gate[i];
      en[i*NB +: NB] = NB'(m_note[i]);
      ea[i] = AB'(m_age[i]);
    end
    es = m_busy && (m_cnt == N) && (m_kind == 4);
    check("gate", 64'(gate), 64'(eg));
    check("voice_note", 64'(voice_note), 64'(en));
    check("age", 64'(dut.age), 64'(ea));
    check("steal", 64'(steal), 64'(es));
    check("ev_ready", 64'(ev_ready), 64'(!m_busy));
  endtask

  task automatic tick();
    @(posedge sample_clock);
    model_edge();
    @(negedge sample_clock);
    check_all();
    if (steal === 1'b1) steal_seen++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 40 && m_busy; k++) tick();
    check("wait_ready_timeout", 64'(m_busy), 64'(0));
  endtask

  // Hold the event until the allocator takes it.
  task automatic send(input bit on, input int note);
    bit done;
    done = 1'b0;
    ev_valid = 1'b1; ev_on = on; ev_note = NB'(note);
    for (int k = 0; k < 40 && !done; k++) begin
      done = !m_busy;
      tick();
    end
    ev_valid = 1'b0;
    check("send_timeout", 64'(done), 64'(1));
  endtask

  // Asynchronous reset applied between edges.
  task automatic do_reset();
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check("rst_gate", 64'(gate), 64'(0));
    check("rst_steal", 64'(steal), 64'(0));
    @(negedge sample_clock);
    @(negedge sample_clock);
    resetn = 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    bit on_q [$];
    int note_q [$];
    int acc0;
    bit took;

    model_reset();
    steal_seen = 0;
    accepts = 0;
    @(negedge sample_clock);
    do_reset();

    // Free allocation from reset.
    send(1'b1, 60); wait_ready();
    send(1'b1, 62); send(1'b1, 64); wait_ready();
    check("no_steal_alloc", 64'(steal_seen), 64'(0));
    check("v1_note", 64'(voice_note[NB +: NB]), 64'(62));

    // Note-off matched and unmatched.
    send(1'b0, 62); wait_ready();
    check("v1_off", 64'(gate[1]), 64'(0));
    send(1'b0, 70); wait_ready();

    // Retrigger of a sounding voice.
    send(1'b1, 60); wait_ready();
    idle(3);

    // Staggered fill, then steal the oldest.
    do_reset();
    send(1'b1, 60); idle(3);
    send(1'b1, 62); idle(3);
    send(1'b1, 64); idle(3);
    send(1'b1, 65); wait_ready(); idle(2);
    steal_seen = 0;
    send(1'b1, 67); wait_ready();
    check("steal_once", 64'(steal_seen), 64'(1));
    check("v0_note67", 64'(voice_note[0 +: NB]), 64'(67));

    // Another steal, reset in the middle of its gap.
    send(1'b1, 69);
    idle(N + 1);
    check("in_gap", 64'(m_busy), 64'(1));
    do_reset();

    // Saturated equal ages: lowest index stolen.
    send(1'b1, 60); send(1'b1, 62); send(1'b1, 64); send(1'b1, 65);
    wait_ready();
    idle(300);
    check("v3_sat", 64'(dut.age[3]), 64'(AMAX));
    send(1'b1, 67); wait_ready();
    check("eq_steal_v0", 64'(voice_note[0 +: NB]), 64'(67));

    // Three queued events under backpressure.
    on_q = '{1'b1, 1'b0, 1'b1};
    note_q = '{70, 62, 72};
    acc0 = accepts;
    for (int k = 0; k < 100 && on_q.size() > 0; k++) begin
      ev_valid = 1'b1; ev_on = on_q[0]; ev_note = NB'(note_q[0]);
      took = !m_busy;
      tick();
      if (took) begin void'(on_q.pop_front()); void'(note_q.pop_front()); end
    end
    ev_valid = 1'b0;
    wait_ready();
    check("queued_accepts", 64'(accepts - acc0), 64'(3));

    // Randomised events, short enough that ages stay clear of saturation.
    do_reset();
    for (int e = 0; e < 20; e++) begin
      send(1'($urandom_range(0, 3) != 0), 60 + int'($urandom_range(0, 5)));
      idle(int'($urandom_range(0, 3)));
    end
    wait_ready();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
